// File: rtl/bit_packer.sv
// bit_packer: packs variable-width fields (0..8 bits) MSB-first into a byte stream.
//
// Fields arrive on a valid/ready input port and are appended to a 24-bit
// left-aligned accumulator. Complete bytes leave on a valid/ready output
// port. A flush command drains every buffered bit. The last partial byte is
// padded with PAD_BIT, and flush_done then pulses for one cycle.
//
// Parameters:
//   PAD_BIT     value written into the unused low bits of a flushed partial byte
//
// Ports:
//   clk         system clock, rising edge
//   nrst        synchronous active-low reset
//   in_valid    field present on in_data/in_len
//   in_ready    packer can accept a field this cycle
//   in_data     field bits, right-aligned
//   in_len      field length; 0 = no-op, 9..15 clamped to 8
//   flush       request to drain all bits, padding the last byte
//   flush_done  one-cycle pulse when the flush is complete
//   out_valid   out_data holds a complete (or padded final) byte
//   out_ready   sink accepts out_data
//   out_data    packed byte, first-packed bit in bit 7
//
// Optional feature (macro BIT_PACKER_STATS_EN):
//   byte_count  wrapping count of bytes popped
//   pad_count   wrapping count of pad bits emitted by flushes
module bit_packer #(
  parameter logic PAD_BIT = 1'b0
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic [3:0]  in_len,
  input  logic        flush,
  output logic        flush_done,
`ifdef BIT_PACKER_STATS_EN
  output logic [15:0] byte_count,
  output logic [15:0] pad_count,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data
);

  typedef enum logic [1:0] {StRun, StFlush, StDone} state_e;

  state_e      state_q, state_d;
  logic [23:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;

  logic [3:0]  len;
  logic [7:0]  field;
  logic [4:0]  place_sh;
  logic [23:0] placed;
  logic [23:0] acc_push;
  logic [4:0]  pop_amt;
  logic        push;
  logic        pop;
  logic        pad_active;
  logic [7:0]  pad_mask;
  logic [7:0]  acc_hi;

  assign len      = (in_len > 4'd8) ? 4'd8 : in_len;
  // Zero the bits above the field so they cannot disturb already-packed data.
  assign field    = in_data & (8'hFF >> (4'd8 - len));
  // Field lands directly below the cnt valid bits; cnt <= 15 keeps this >= 1.
  assign place_sh = 5'd24 - cnt_q - {1'b0, len};
  assign placed   = {16'h0000, field} << place_sh;

  assign in_ready = (state_q == StRun) && (cnt_q <= 5'd15);
  assign out_valid = (cnt_q >= 5'd8) || ((state_q == StFlush) && (cnt_q != 5'd0));
  assign flush_done = (state_q == StDone);

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Padding applies only to the final partial byte of a flush.
  assign pad_active = (state_q == StFlush) && (cnt_q != 5'd0) && (cnt_q < 5'd8);
  assign pad_mask   = 8'hFF >> cnt_q[2:0];
  assign acc_hi     = acc_q[23:16];

  always_comb begin
    out_data = acc_hi;
    if (pad_active) begin
      out_data = PAD_BIT ? (acc_hi | pad_mask) : (acc_hi & ~pad_mask);
    end
  end

  // Bits below the valid region are always zero, so the push is a plain OR.
  // The push is placed against the pre-pop count and the pop shift follows.
  always_comb begin
    acc_push = push ? (acc_q | placed) : acc_q;
    acc_d    = pop ? (acc_push << 8) : acc_push;
    pop_amt  = 5'd0;
    if (pop) begin
      pop_amt = (cnt_q >= 5'd8) ? 5'd8 : cnt_q;
    end
    cnt_d = cnt_q - pop_amt + (push ? {1'b0, len} : 5'd0);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        // Only sampled when in_ready; a coincident field is pushed first.
        if (in_ready && flush) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        if (cnt_d == 5'd0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StRun;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= StRun;
      acc_q   <= 24'h000000;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef BIT_PACKER_STATS_EN
  logic [15:0] byte_count_q;
  logic [15:0] pad_count_q;
  logic [4:0]  pad_bits;

  assign pad_bits = 5'd8 - cnt_q;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      byte_count_q <= 16'h0000;
      pad_count_q  <= 16'h0000;
    end else if (pop) begin
      byte_count_q <= byte_count_q + 16'h0001;
      if (pad_active) begin
        pad_count_q <= pad_count_q + {11'h000, pad_bits};
      end
    end
  end

  assign byte_count = byte_count_q;
  assign pad_count  = pad_count_q;
`endif

endmodule

// File: doc/bit_packer.md
Name: bit_packer

Overview:
- Sequential write-side counterpart to the team's funnel-shifter byte aligner.
- The aligner extracts variable bit windows from a byte stream; bit_packer accepts variable-width fields (0-8 bits) and packs them MSB-first into a continuous byte stream.
- It uses valid/ready handshakes on both sides and a flush command that pads and emits the final partial byte.
- It sits in front of any byte sink, such as a FIFO or serializer.

Parameters:
PAD_BIT, 1'b0, value written into unused low bits of the final byte emitted by a flush.

Ports:
clk  input  1  system clock, rising edge
nrst  input  1  synchronous active-low reset
in_valid  input  1  field present on in_data/in_len
in_ready  output  1  packer can accept a field this cycle
in_data  input  8  field bits, right-aligned; only in_data[len-1:0] used
in_len  input  4  field length; 0 = no-op, 9..15 clamped to 8
flush  input  1  request to drain all bits, padding the last byte
flush_done  output  1  one-cycle pulse when flush is complete
out_valid  output  1  out_data holds a complete byte
out_ready  input  1  sink accepts out_data
out_data  output  8  packed byte, first-packed bit in bit 7

Behaviour:
- Storage: 24-bit accumulator acc and a 5-bit bit count cnt (0..23). Valid bits are left-aligned at acc[23:24-cnt].
- Push (in_valid && in_ready): field bits in_data[len-1:0] go to acc[23-cnt : 24-cnt-len]; cnt += len. Bit len-1 is packed first.
- in_len 0: field accepted, acc and cnt unchanged. in_len > 8: len = 8.
- out_data = acc[23:16] at all times, except in FLUSH with 0 < cnt < 8: the low (8-cnt) bits are forced to PAD_BIT.
- out_valid = (cnt >= 8) || (state == FLUSH && cnt > 0).
- Pop (out_valid && out_ready): acc <<= 8, cnt -= 8; if cnt < 8 (flush remainder), cnt becomes 0.
- Push and pop in the same cycle: new cnt = cnt - popped + len. Pushed bits land relative to the pre-pop cnt, then the shift applies.
- in_ready = (state == RUN) && (cnt <= 15). This is registered-state based only, with no combinational path from out_ready.
- Maximum cnt is 15 + 8 = 23, so the accumulator never overflows.
- While out_valid && !out_ready, out_data and out_valid hold stable. A push never alters acc[23:16] when cnt >= 8.
- Latency: a byte completed by a push is presented on out_valid the following cycle. Sustained 8-bit fields with out_ready = 1 give 1 byte/cycle with in_ready held high.
- FSM:
  - RUN: flush is sampled only when in_ready = 1. If in_valid and flush coincide, the field is pushed first and then included in the flush. flush -> FLUSH.
  - FLUSH: in_ready = 0. Emit bytes until cnt == 0, with the last partial byte padded. When cnt == 0 -> DONE. If cnt is already 0 on entry, go to DONE on the next cycle.
  - DONE: flush_done = 1 for exactly one cycle, then -> RUN.
- Reset (nrst = 0 at a clock edge, including mid-flush or mid-stall):
  - acc = 0, cnt = 0, state = RUN.
  - out_valid = 0, out_data = 0x00, flush_done = 0, in_ready = 1 in the cycle after reset.
  - Buffered bits are discarded.

Optional Feature:
BIT_PACKER_STATS_EN
- Defined: adds output byte_count[15:0], reset to 0, incremented on every pop, wrapping 0xFFFF -> 0x0000. It also adds output pad_count[15:0], incremented by the number of pad bits on each padded flush byte.
- Undefined: both ports and their counters are absent; all other behaviour is identical.

Test Plan:
- Reset: hold nrst = 0 for 2 cycles -> out_valid = 0, out_data = 0x00, in_ready = 1, flush_done = 0.
- Push (len4, 0xA) then (len4, 0x5), out_ready = 1 -> out_valid = 1 with out_data = 0xA5 one cycle after the second accept; then cnt = 0.
- Push three (len3, 0b101), then flush, PAD_BIT = 0:
  - out_data = 0xB6, then 0x80.
  - flush_done pulses 1 cycle after the 0x80 handshake.
  - in_ready = 0 during the flush.
  - Repeat with PAD_BIT = 1 -> last byte 0xFF.
- Backpressure: out_ready = 0, push (len8, 0x11), then (len8, 0x22):
  - in_ready drops once cnt = 16.
  - out_data holds 0x11 stable.
  - Raise out_ready -> bytes 0x11 then 0x22 in order.
- Streaming: 32 consecutive (len8, i) fields with out_ready = 1 -> in_ready never drops; bytes 0..31 emerge one per cycle with 1-cycle latency.
- Edge cases:
  - (len0, 0xFF) -> accepted, no output.
  - (len12, 0xC3) -> treated as len 8, byte 0xC3.
  - Assert nrst during FLUSH with cnt = 5 -> buffer cleared, no flush_done, in_ready = 1 after reset.
